// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX FIFO write port.
// Optional per-message ASCII source tag byte: define UART_TX_ARB_SRC_TAG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_MSG_LEN = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 fifo_wr_o,
  output logic [7:0]           fifo_data_o,
  input  logic                 fifo_full_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 forced_rel_o
);

  localparam int unsigned NR = NUM_REQ;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_TX_ARB_SRC_TAG_EN
  typedef enum logic [1:0] {IDLE, TAG, XFER} state_t;
`else
  typedef enum logic {IDLE, XFER} state_t;
`endif

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      count_q, count_d;
  logic            forced_q, forced_d;

  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_valid;
  logic               gnt_last;
  logic [7:0]         gnt_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      count_q   <= '0;
      forced_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      forced_q  <= forced_d;
    end
  end

  // First valid source scanning upward from the RR pointer, with wrap.
  always_comb begin
    logic        found;
    int unsigned idx;
    found    = 1'b0;
    idx      = 0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(rr_ptr_q) + k) % NR;
      if (!found && req_valid_i[IW'(idx)]) begin
        found    = 1'b1;
        pick_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (IW'(i) == gnt_idx_q) begin
        gnt_valid = req_valid_i[i];
        gnt_last  = req_last_i[i];
        gnt_data  = req_data_i[8*i +: 8];
      end
    end
  end

  assign gnt_oh   = (state_q != IDLE) ? (NUM_REQ'(1) << gnt_idx_q) : '0;
  assign next_ptr = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    count_d     = count_q;
    forced_d    = 1'b0;
    req_ready_o = '0;
    fifo_wr_o   = 1'b0;
    fifo_data_o = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          gnt_idx_d = pick_idx;
          count_d   = '0;
`ifdef UART_TX_ARB_SRC_TAG_EN
          state_d   = TAG;
`else
          state_d   = XFER;
`endif
        end
      end
`ifdef UART_TX_ARB_SRC_TAG_EN
      TAG: begin
        if (!fifo_full_i) begin
          fifo_wr_o   = 1'b1;
          fifo_data_o = 8'h30 + 8'(gnt_idx_q);
          state_d     = XFER;
        end
      end
`endif
      XFER: begin
        if (!fifo_full_i) begin
          req_ready_o = gnt_oh;
          if (gnt_valid) begin
            fifo_wr_o   = 1'b1;
            fifo_data_o = gnt_data;
            count_d     = count_q + 8'd1;
            // A last byte landing on the length limit is a normal release.
            if (gnt_last || (count_q == 8'(MAX_MSG_LEN - 1))) begin
              state_d  = IDLE;
              rr_ptr_d = next_ptr;
              forced_d = !gnt_last;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o      = gnt_oh;
  assign busy_o       = (state_q != IDLE);
  assign forced_rel_o = forced_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, MAX_MSG_LEN=4).
module tb_uart_tx_arbiter;

  localparam int NR = 4;
`ifdef UART_TX_ARB_SRC_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr;
  logic [7:0]      fifo_data;
  logic            fifo_full;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            forced_rel;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_MSG_LEN(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .fifo_wr_o(fifo_wr), .fifo_data_o(fifo_data),
    .fifo_full_i(fifo_full), .grant_o(grant), .busy_o(busy),
    .forced_rel_o(forced_rel)
  );

  always #5 clk = ~clk;

  typedef struct { int src; logic [7:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [8:0]  src_q[NR][$];
  logic [NR-1:0] acc_pending = '0;
  int checks = 0, errors = 0;
  int wr_count = 0, forced_count = 0, forced_at = -1;

  task automatic check(string name, int unsigned act, int unsigned expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic add_src(int s, logic [7:0] d, logic last);
    src_q[s].push_back({last, d});
  endtask

  task automatic exp_b(int s, logic [7:0] d);
    exp_q.push_back('{s, d});
  endtask

  task automatic exp_tag(int s);
`ifdef UART_TX_ARB_SRC_TAG_EN
    exp_q.push_back('{s, 8'(8'h30 + s)});
`endif
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #2; n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_writes(int target);
    int n = 0;
    while (wr_count < target && n < 200) begin
      @(negedge clk); #2; n++;
    end
    check("write_wait_timeout", (wr_count >= target) ? 1 : 0, 1);
  endtask

  // Source model: pops a byte once it was accepted, then presents the next one.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (rst_n && acc_pending[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = src_q[i][0][7:0];
        req_last[i]         = src_q[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = '0;
        req_last[i]         = 1'b0;
      end
    end
    #1;
    acc_pending = req_valid & req_ready;
  end

  // Monitor: every FIFO write must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk); #1;
    if (fifo_wr) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", fifo_data, 9'h100);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", fifo_data, e.data);
        check("wr_src", grant, 1 << e.src);
      end
    end
    if ((req_ready & ~grant) != 0) check("ready_not_granted", req_ready & ~grant, 0);
    if (forced_rel) begin
      forced_count++;
      forced_at = wr_count;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, f0;
    rst_n = 1'b0; fifo_full = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", fifo_wr, 0);
    check("rst_data", fifo_data, 0);
    check("rst_ready", req_ready, 0);
    check("rst_forced", forced_rel, 0);
    rst_n = 1'b1;

    // Sources 0 and 2 from pointer 0, then all four from pointer 3.
    add_src(0, 8'h10, 0); add_src(0, 8'h11, 1);
    add_src(2, 8'h20, 0); add_src(2, 8'h21, 1);
    exp_tag(0); exp_b(0, 8'h10); exp_b(0, 8'h11);
    exp_tag(2); exp_b(2, 8'h20); exp_b(2, 8'h21);
    wait_drain();
    for (int i = 0; i < NR; i++) add_src(i, 8'(8'hD0 + i), 1);
    exp_tag(3); exp_b(3, 8'hD3);
    exp_tag(0); exp_b(0, 8'hD0);
    exp_tag(1); exp_b(1, 8'hD1);
    exp_tag(2); exp_b(2, 8'hD2);
    wait_drain();

    // Single source 1: grant one cycle after valid, busy drops after last.
    add_src(1, 8'h41, 0); add_src(1, 8'h42, 0); add_src(1, 8'h43, 1);
    exp_tag(1); exp_b(1, 8'h41); exp_b(1, 8'h42); exp_b(1, 8'h43);
    @(negedge clk); #2;
    check("grant_before_valid_seen", grant, 0);
    @(negedge clk); #2;
    check("grant_latency", grant, 4'b0010);
    check("busy_on_grant", busy, 1);
    wait_drain();
    @(negedge clk); #2;
    check("busy_after_last", busy, 0);
    check("grant_after_last", grant, 0);

    // FIFO full for 5 cycles after byte 2 of 4; last byte lands on the limit.
    base = wr_count; f0 = forced_count;
    add_src(0, 8'h50, 0); add_src(0, 8'h51, 0); add_src(0, 8'h52, 0); add_src(0, 8'h53, 1);
    exp_tag(0); exp_b(0, 8'h50); exp_b(0, 8'h51); exp_b(0, 8'h52); exp_b(0, 8'h53);
    wait_writes(base + 2 + TAGN);
    @(posedge clk); #1;
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk); #2;
      check("full_no_wr", fifo_wr, 0);
      check("full_no_ready", req_ready, 0);
      check("full_grant_held", grant, 4'b0001);
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    wait_drain();
    check("no_forced_last_at_max", forced_count - f0, 0);

    // Forced release after 4 bytes of a 6-byte message, source 2 waiting.
    base = wr_count; f0 = forced_count;
    for (int b = 0; b < 6; b++) add_src(1, 8'(8'h60 + b), (b == 5) ? 1'b1 : 1'b0);
    add_src(2, 8'h70, 0); add_src(2, 8'h71, 1);
    exp_tag(1);
    for (int b = 0; b < 4; b++) exp_b(1, 8'(8'h60 + b));
    exp_tag(2); exp_b(2, 8'h70); exp_b(2, 8'h71);
    exp_tag(1); exp_b(1, 8'h64); exp_b(1, 8'h65);
    wait_drain();
    check("forced_pulses", forced_count - f0, 1);
    check("forced_position", forced_at, base + 4 + TAGN);

    // Reset after 2 of 5 bytes; re-arbitration restarts at source 0.
    base = wr_count;
    for (int b = 0; b < 5; b++) add_src(2, 8'(8'h80 + b), (b == 4) ? 1'b1 : 1'b0);
    exp_tag(2);
    for (int b = 0; b < 5; b++) exp_b(2, 8'(8'h80 + b));
    wait_writes(base + 2 + TAGN);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_wr", fifo_wr, 0);
    check("async_rst_ready", req_ready, 0);
    check("async_rst_data", fifo_data, 0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    acc_pending = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    add_src(3, 8'hA3, 1); add_src(0, 8'hA0, 1);
    exp_tag(0); exp_b(0, 8'hA0);
    exp_tag(3); exp_b(3, 8'hA3);
    wait_drain();

    // Single-byte message from source 3 (tag byte precedes it when enabled).
    add_src(3, 8'h55, 1);
    exp_tag(3); exp_b(3, 8'h55);
    wait_drain();
    @(negedge clk); #2;
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
